qmem_sram16_bridge: RTL and testbench
=====================================

// Module: qmem_sram16_bridge
// PURPOSE
//  qmem slave that converts 32-bit requests from the arbiter's master port into one or two
//  16-bit async SRAM cycles with programmable wait states. Sits directly downstream of the
//  qmem arbiter; its qs_ack/qs_err close the arbitrated transaction.
// PARAMETERS
//  QAW 32  qmem byte address width
//  QDW 32  qmem data width (fixed 32)
//  QSW 4   qmem byte select width (QDW/8)
//  SAW 18  SRAM 16-bit word address width
//  WS  2   wait states per SRAM phase; phase length = WS+1 cycles; legal range 1..7
// PORTS
//  clk         in   1    clock
//  rst         in   1    reset, asynchronous, active-high
//  qs_cs       in   1    request valid; held with all request fields until ack/err
//  qs_we       in   1    1 = write, 0 = read
//  qs_sel      in   QSW  byte enables; sel[1:0] -> low half, sel[3:2] -> high half
//  qs_adr      in   QAW  byte address; adr[1:0] ignored
//  qs_dat_w    in   QDW  write data
//  qs_dat_r    out  QDW  read data, registered, valid in ack cycle
//  qs_ack      out  1    one-cycle completion pulse
//  qs_err      out  1    one-cycle error pulse (address out of range)
//  sram_adr    out  SAW  SRAM word address
//  sram_dat_w  out  16   SRAM write data
//  sram_dat_r  in   16   SRAM read data
//  sram_dat_oe out  1    data pad output enable
//  sram_ce_n   out  1    chip enable, active low
//  sram_oe_n   out  1    output enable, active low
//  sram_we_n   out  1    write enable, active low
//  sram_ub_n   out  1    upper byte enable, active low
//  sram_lb_n   out  1    lower byte enable, active low
// BEHAVIOUR
//  - Reset (any time, incl. mid-access): state IDLE, counter 0, qs_ack=qs_err=0, qs_dat_r=0,
//    ce_n=oe_n=we_n=ub_n=lb_n=1, dat_oe=0, sram_adr=0, sram_dat_w=0.
//  - SRAM outputs are registered. No glitch on we_n. Strobes are high in IDLE/DONE/ERR.
//  - States: IDLE, LO, HI, DONE, ERR.
//  - IDLE, qs_cs=1:
//      if adr[QAW-1:SAW+1] != 0 -> ERR
//      else if sel[1:0] != 0 -> LO
//      else if sel[3:2] != 0 -> HI
//      else -> DONE
//  - Request fields are latched on leaving IDLE. Later changes on the qs_* inputs are ignored.
//  - LO: sram_adr = {adr[SAW:2],1'b0}; HI: sram_adr = {adr[SAW:2],1'b1}.
//    Each phase lasts WS+1 cycles, counted by cnt = 0..WS.
//  - Read phase:
//      ce_n=0, oe_n=0, we_n=1, ub_n/lb_n = ~sel of that half.
//      sram_dat_r is captured into the matching qs_dat_r half on the cnt==WS cycle.
//  - Write phase:
//      ce_n=0, oe_n=1, dat_oe=1, sram_dat_w = that half of dat_w.
//      we_n=0 for cnt < WS and 1 on cnt==WS (address/data hold cycle).
//  - LO end: go to HI if sel[3:2] != 0, else DONE. HI end: DONE.
//  - DONE: qs_ack=1 for one cycle -> IDLE. ERR: qs_err=1 for one cycle -> IDLE. No SRAM
//    activity for ERR.
//  - IDLE samples a new request the cycle after DONE/ERR. Back-to-back transfers have no
//    extra bubble.
//  - A skipped half reads back as 16'h0000. qs_dat_r is cleared on leaving IDLE for a read;
//    it is unchanged on writes.
//  - Latency with first qs_cs cycle = 0: ack at cycle 1 + n*(WS+1) + 0, with the DONE cycle
//    included, where n = halves accessed. Full word at WS=2: ack at cycle 7. sel=0: ack at
//    cycle 1. Error: err at cycle 1.
//  - qs_cs dropped mid-transaction is a protocol violation: the access completes and acks.
//  - cnt width = clog2(WS+1). cnt resets to 0 on every phase entry.
// STRUCTURE
//  - Shared qmem_defs.vh holds the QAW/QDW/QSW defaults used by the arbiter and the bridge.
//  - State encodings are module-local localparams.
//  - Single module, no sub-module. SRAM pad tristate (dat_oe) is resolved at top level.
// TESTING
//  1. Read 32b, adr=0x0000_0008, sel=4'hF, WS=2, SRAM word4=16'h1234, word5=16'hABCD
//     -> ack at cycle 7, qs_dat_r=32'hABCD_1234; oe_n low for 6 cycles.
//  2. Write adr=0x10, sel=4'h3, dat_w=32'hDEAD_BEEF -> single phase at sram_adr=8,
//     dat_w=16'hBEEF, we_n low for 2 cycles, ack at cycle 4.
//  3. Write sel=4'h4, dat_w=32'h0055_0000, adr=0x10 -> HI only at sram_adr=9, ub_n=1,
//     lb_n=0, ack at cycle 4.
//  4. adr=1<<(SAW+1) -> qs_err at cycle 1, ce_n stays 1, no ack.
//  5. Two back-to-back reads, cs held across ack with a new adr -> second LO starts the
//     cycle after IDLE; no cross-contamination of data.
//  6. rst asserted during HI write -> we_n/ce_n high and state IDLE immediately, no ack.
//     A fresh read after reset completes normally.

Source files
------------

// File: rtl/qmem_sram16_bridge_pkg.sv
// qmem_sram16_bridge_pkg
//   Shared qmem bus defaults used by the arbiter and by the SRAM bridge.
//   There are no ports. Importers use these values as parameter defaults, so
//   every qmem block in the slice agrees on the bus widths.
package qmem_sram16_bridge_pkg;

  localparam int QMEM_AW = 32;  // qmem byte address width
  localparam int QMEM_DW = 32;  // qmem data width (fixed)
  localparam int QMEM_SW = 4;   // qmem byte select width (QMEM_DW/8)
  localparam int SRAM_DW = 16;  // external SRAM data width

endpackage

// File: rtl/qmem_sram16_bridge.sv
// qmem_sram16_bridge
//   A qmem slave that turns each 32-bit request into zero, one or two 16-bit
//   async SRAM cycles. Each SRAM phase lasts WS+1 cycles.
//   Ports:
//     clk, rst      clock; asynchronous active-high reset
//     qs_cs/qs_we/qs_sel/qs_adr/qs_dat_w
//                   qmem request. It is held until ack or err.
//     qs_dat_r      registered read data, valid in the ack cycle
//     qs_ack/qs_err one-cycle completion / out-of-range pulses
//     sram_adr      SRAM word address
//     sram_dat_w/sram_dat_r/sram_dat_oe
//                   SRAM data bus; the pad tristate is resolved above this block
//     sram_ce_n/oe_n/we_n/ub_n/lb_n
//                   active-low SRAM strobes. All strobes are registered.
module qmem_sram16_bridge
  import qmem_sram16_bridge_pkg::*;
#(
  parameter int QAW = QMEM_AW,
  parameter int QDW = QMEM_DW,
  parameter int QSW = QMEM_SW,
  parameter int SAW = 18,
  parameter int WS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                qs_cs,
  input  logic                qs_we,
  input  logic [QSW-1:0]      qs_sel,
  input  logic [QAW-1:0]      qs_adr,
  input  logic [QDW-1:0]      qs_dat_w,
  output logic [QDW-1:0]      qs_dat_r,
  output logic                qs_ack,
  output logic                qs_err,
  output logic [SAW-1:0]      sram_adr,
  output logic [SRAM_DW-1:0]  sram_dat_w,
  input  logic [SRAM_DW-1:0]  sram_dat_r,
  output logic                sram_dat_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  localparam int CW = (WS < 1) ? 1 : $clog2(WS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;

  // Request fields captured while idle. After the state leaves IDLE, these
  // registers hold the request and the live qs_* inputs are ignored.
  logic                 we_reg;
  logic [QSW-1:0]       sel_reg;
  logic [SAW-2:0]       word_reg;
  logic [QDW-1:0]       dat_w_reg;

  // The effective request is the live bus in IDLE and the latched copy
  // afterwards. This lets the first phase's outputs be registered on the
  // same edge that leaves IDLE.
  logic                 req_idle;
  logic                 r_we;
  logic [QSW-1:0]       r_sel;
  logic [SAW-2:0]       r_word;
  logic [QDW-1:0]       r_dat;
  logic                 adr_oor;

  logic [QDW-1:0]       dat_r_next;
  logic                 ack_next, err_next;
  logic [SAW-1:0]       adr_next;
  logic [SRAM_DW-1:0]   dat_w_next;
  logic                 dat_oe_next, ce_n_next, oe_n_next, we_n_next, ub_n_next, lb_n_next;
  logic                 hi_phase;
  logic [1:0]           half_sel;

  // adr[1:0] only selects bytes inside a word, and qs_sel already covers that.
  logic                 unused_adr_bits;
  assign unused_adr_bits = ^qs_adr[1:0];

  assign req_idle = (state_reg == ST_IDLE);
  assign r_we     = req_idle ? qs_we            : we_reg;
  assign r_sel    = req_idle ? qs_sel           : sel_reg;
  assign r_word   = req_idle ? qs_adr[SAW:2]    : word_reg;
  assign r_dat    = req_idle ? qs_dat_w         : dat_w_reg;
  assign adr_oor  = |qs_adr[QAW-1:SAW+1];

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (qs_cs) begin
          if (adr_oor)              state_next = ST_ERR;
          else if (|qs_sel[1:0])    state_next = ST_LO;
          else if (|qs_sel[3:2])    state_next = ST_HI;
          else                      state_next = ST_DONE;
        end
      end
      ST_LO: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = (|r_sel[3:2]) ? ST_HI : ST_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_HI: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output values for the next cycle. They are computed from the next state
  // and the next count, then registered, so the strobes cannot glitch.
  always_comb begin
    ack_next    = (state_next == ST_DONE);
    err_next    = (state_next == ST_ERR);
    adr_next    = sram_adr;
    dat_w_next  = sram_dat_w;
    dat_oe_next = 1'b0;
    ce_n_next   = 1'b1;
    oe_n_next   = 1'b1;
    we_n_next   = 1'b1;
    ub_n_next   = 1'b1;
    lb_n_next   = 1'b1;
    hi_phase    = (state_next == ST_HI);
    half_sel    = hi_phase ? r_sel[3:2] : r_sel[1:0];

    if (state_next == ST_LO || state_next == ST_HI) begin
      ce_n_next = 1'b0;
      adr_next  = {r_word, hi_phase};
      ub_n_next = ~half_sel[1];
      lb_n_next = ~half_sel[0];
      if (r_we) begin
        dat_oe_next = 1'b1;
        dat_w_next  = hi_phase ? r_dat[31:16] : r_dat[15:0];
        // The last cycle of a write phase keeps address and data stable
        // while we_n has already risen.
        we_n_next   = (cnt_next == CNT_LAST);
      end else begin
        oe_n_next = 1'b0;
      end
    end

    // Read data: cleared when a read starts, so a skipped half returns
    // zero. Each half is captured on the last cycle of its phase.
    dat_r_next = qs_dat_r;
    if (req_idle && qs_cs && !qs_we) begin
      dat_r_next = '0;
    end else if (!we_reg && cnt_reg == CNT_LAST) begin
      if (state_reg == ST_LO) dat_r_next[15:0]  = sram_dat_r;
      if (state_reg == ST_HI) dat_r_next[31:16] = sram_dat_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      sel_reg     <= '0;
      word_reg    <= '0;
      dat_w_reg   <= '0;
      qs_dat_r    <= '0;
      qs_ack      <= 1'b0;
      qs_err      <= 1'b0;
      sram_adr    <= '0;
      sram_dat_w  <= '0;
      sram_dat_oe <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      if (req_idle) begin
        we_reg    <= qs_we;
        sel_reg   <= qs_sel;
        word_reg  <= qs_adr[SAW:2];
        dat_w_reg <= qs_dat_w;
      end
      qs_dat_r    <= dat_r_next;
      qs_ack      <= ack_next;
      qs_err      <= err_next;
      sram_adr    <= adr_next;
      sram_dat_w  <= dat_w_next;
      sram_dat_oe <= dat_oe_next;
      sram_ce_n   <= ce_n_next;
      sram_oe_n   <= oe_n_next;
      sram_we_n   <= we_n_next;
      sram_ub_n   <= ub_n_next;
      sram_lb_n   <= lb_n_next;
    end
  end

endmodule

// File: tb/tb_qmem_sram16_bridge.sv
module tb_qmem_sram16_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qs_cs = 1'b0;
  logic        qs_we = 1'b0;
  logic [3:0]  qs_sel = 4'h0;
  logic [31:0] qs_adr = 32'h0;
  logic [31:0] qs_dat_w = 32'h0;
  logic [31:0] qs_dat_r;
  logic        qs_ack, qs_err;
  logic [17:0] sram_adr;
  logic [15:0] sram_dat_w, sram_dat_r;
  logic        sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qmem_sram16_bridge #(.QAW(32), .QDW(32), .QSW(4), .SAW(18), .WS(2)) dut (
    .clk(clk), .rst(rst),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr), .qs_dat_w(qs_dat_w),
    .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .sram_adr(sram_adr), .sram_dat_w(sram_dat_w), .sram_dat_r(sram_dat_r),
    .sram_dat_oe(sram_dat_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // Small SRAM model: 64 words, byte-lane writes, and a bench-side preload port.
  logic [15:0] mem [0:63];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_adr = 6'd0;
  logic [15:0] pl_dat = 16'h0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_adr] <= pl_dat;
    else if (!sram_ce_n && !sram_we_n && sram_dat_oe) begin
      if (!sram_lb_n) mem[sram_adr[5:0]][7:0]  <= sram_dat_w[7:0];
      if (!sram_ub_n) mem[sram_adr[5:0]][15:8] <= sram_dat_w[15:8];
    end
  end

  assign sram_dat_r = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr[5:0]] : 16'hFFFF;

  // Observations returned by run_txn.
  int          e_cyc, f_ce, oe_l, we_l, ce_l;
  bit          ak, er;
  logic [31:0] rd;
  logic [17:0] af;
  logic        ub, lb;
  logic [15:0] wd;

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_adr = a; pl_dat = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Drives one request and records what the SRAM side and the qmem side did.
  // Cycle 0 is the cycle in which the request is first driven.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input bit no_wait, input bit hold_cs,
                         input bit glitch);
    e_cyc = -1; f_ce = -1; oe_l = 0; we_l = 0; ce_l = 0;
    ak = 1'b0; er = 1'b0; rd = 32'h0; af = 18'h0; ub = 1'b1; lb = 1'b1; wd = 16'h0;
    if (!no_wait) @(negedge clk);
    qs_cs = 1'b1; qs_we = we; qs_sel = sel; qs_adr = adr; qs_dat_w = dat;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!sram_ce_n) begin
        ce_l++;
        if (f_ce < 0) begin f_ce = cyc; af = sram_adr; end
        ub = sram_ub_n; lb = sram_lb_n;
      end
      if (!sram_oe_n) oe_l++;
      if (!sram_we_n) begin we_l++; wd = sram_dat_w; end
      if (qs_ack || qs_err) begin
        e_cyc = cyc; ak = qs_ack; er = qs_err; rd = qs_dat_r;
        if (!hold_cs) qs_cs = 1'b0;
        break;
      end
      if (glitch && cyc == 1) begin
        qs_cs = 1'b0; qs_adr = 32'h40; qs_sel = 4'h0; qs_we = ~we;
      end
    end
    $display("txn we=%0b sel=%h adr=%h dat=%h -> end_cyc=%0d ack=%0b err=%0b rdata=%h ce_low=%0d oe_low=%0d we_low=%0d",
             we, sel, adr, dat, e_cyc, ak, er, rd, ce_l, oe_l, we_l);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (qs_ack !== 1'b0)       begin n_fail++; $display("FAIL rst_ack: got %b want 0", qs_ack); end
    n_cmp++; if (qs_err !== 1'b0)       begin n_fail++; $display("FAIL rst_err: got %b want 0", qs_err); end
    n_cmp++; if (qs_dat_r !== 32'h0)    begin n_fail++; $display("FAIL rst_dat_r: got %h want 0", qs_dat_r); end
    n_cmp++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111)
      begin n_fail++; $display("FAIL rst_strobes: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_cmp++; if (sram_dat_oe !== 1'b0)  begin n_fail++; $display("FAIL rst_dat_oe: got %b want 0", sram_dat_oe); end
    n_cmp++; if (sram_adr !== 18'h0)    begin n_fail++; $display("FAIL rst_sram_adr: got %h want 0", sram_adr); end
    n_cmp++; if (sram_dat_w !== 16'h0)  begin n_fail++; $display("FAIL rst_sram_dat_w: got %h want 0", sram_dat_w); end
    rst = 1'b0;
  endtask

  task automatic test_read32;
    run_txn(1'b0, 4'hF, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 7)             begin n_fail++; $display("FAIL read32_ack_cyc: got %0d want 7", e_cyc); end
    n_cmp++; if (rd !== 32'hABCD_1234)    begin n_fail++; $display("FAIL read32_data: got %h want abcd1234", rd); end
    n_cmp++; if (oe_l !== 6)              begin n_fail++; $display("FAIL read32_oe_low: got %0d want 6", oe_l); end
    n_cmp++; if (we_l !== 0)              begin n_fail++; $display("FAIL read32_we_low: got %0d want 0", we_l); end
    n_cmp++; if (af !== 18'd4)            begin n_fail++; $display("FAIL read32_first_adr: got %h want 4", af); end
    @(negedge clk);
    n_cmp++; if (qs_ack !== 1'b0)         begin n_fail++; $display("FAIL read32_ack_pulse: got %b want 0", qs_ack); end
  endtask

  task automatic test_write_lo;
    run_txn(1'b1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 4)             begin n_fail++; $display("FAIL wlo_ack_cyc: got %0d want 4", e_cyc); end
    n_cmp++; if (af !== 18'd8)            begin n_fail++; $display("FAIL wlo_adr: got %h want 8", af); end
    n_cmp++; if (wd !== 16'hBEEF)         begin n_fail++; $display("FAIL wlo_dat_w: got %h want beef", wd); end
    n_cmp++; if (we_l !== 2)              begin n_fail++; $display("FAIL wlo_we_low: got %0d want 2", we_l); end
    n_cmp++; if (ce_l !== 3)              begin n_fail++; $display("FAIL wlo_ce_low: got %0d want 3", ce_l); end
    n_cmp++; if (oe_l !== 0)              begin n_fail++; $display("FAIL wlo_oe_low: got %0d want 0", oe_l); end
    n_cmp++; if (rd !== 32'hABCD_1234)    begin n_fail++; $display("FAIL wlo_dat_r_kept: got %h want abcd1234", rd); end
    n_cmp++; if (mem[8] !== 16'hBEEF)     begin n_fail++; $display("FAIL wlo_mem8: got %h want beef", mem[8]); end
    n_cmp++; if (mem[9] !== 16'h7777)     begin n_fail++; $display("FAIL wlo_mem9: got %h want 7777", mem[9]); end
  endtask

  task automatic test_write_hi;
    run_txn(1'b1, 4'h4, 32'h0000_0010, 32'h0055_0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 4)             begin n_fail++; $display("FAIL whi_ack_cyc: got %0d want 4", e_cyc); end
    n_cmp++; if (af !== 18'd9)            begin n_fail++; $display("FAIL whi_adr: got %h want 9", af); end
    n_cmp++; if ({ub, lb} !== 2'b10)      begin n_fail++; $display("FAIL whi_ub_lb: got %b want 10", {ub, lb}); end
    n_cmp++; if (wd !== 16'h0055)         begin n_fail++; $display("FAIL whi_dat_w: got %h want 0055", wd); end
    n_cmp++; if (mem[9] !== 16'h7755)     begin n_fail++; $display("FAIL whi_mem9: got %h want 7755", mem[9]); end
    n_cmp++; if (mem[8] !== 16'hBEEF)     begin n_fail++; $display("FAIL whi_mem8: got %h want beef", mem[8]); end
  endtask

  task automatic test_read_hi_only;
    run_txn(1'b0, 4'hC, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 4)             begin n_fail++; $display("FAIL rhi_ack_cyc: got %0d want 4", e_cyc); end
    n_cmp++; if (rd !== 32'hABCD_0000)    begin n_fail++; $display("FAIL rhi_data: got %h want abcd0000", rd); end
    n_cmp++; if (af !== 18'd5)            begin n_fail++; $display("FAIL rhi_adr: got %h want 5", af); end
  endtask

  task automatic test_error;
    run_txn(1'b0, 4'hF, 32'h0008_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 1)             begin n_fail++; $display("FAIL err_cyc: got %0d want 1", e_cyc); end
    n_cmp++; if ({ak, er} !== 2'b01)      begin n_fail++; $display("FAIL err_ack_err: got %b want 01", {ak, er}); end
    n_cmp++; if (ce_l !== 0)              begin n_fail++; $display("FAIL err_ce_low: got %0d want 0", ce_l); end
    @(negedge clk);
    n_cmp++; if ({qs_ack, qs_err, sram_ce_n} !== 3'b001)
      begin n_fail++; $display("FAIL err_after: got %b want 001", {qs_ack, qs_err, sram_ce_n}); end
  endtask

  task automatic test_sel_zero;
    run_txn(1'b0, 4'h0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 1)             begin n_fail++; $display("FAIL sel0_ack_cyc: got %0d want 1", e_cyc); end
    n_cmp++; if ({ak, er} !== 2'b10)      begin n_fail++; $display("FAIL sel0_ack_err: got %b want 10", {ak, er}); end
    n_cmp++; if (rd !== 32'h0)            begin n_fail++; $display("FAIL sel0_data: got %h want 0", rd); end
    n_cmp++; if (ce_l !== 0)              begin n_fail++; $display("FAIL sel0_ce_low: got %0d want 0", ce_l); end
  endtask

  task automatic test_back_to_back;
    run_txn(1'b0, 4'hF, 32'h0000_0018, 32'h0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (e_cyc !== 7)             begin n_fail++; $display("FAIL b2b1_ack_cyc: got %0d want 7", e_cyc); end
    n_cmp++; if (rd !== 32'hF0F0_0F0F)    begin n_fail++; $display("FAIL b2b1_data: got %h want f0f00f0f", rd); end
    // New address is driven in the ack cycle with cs still high.
    run_txn(1'b0, 4'h3, 32'h0000_001C, 32'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (f_ce !== 2)              begin n_fail++; $display("FAIL b2b2_first_lo: got %0d want 2", f_ce); end
    n_cmp++; if (e_cyc !== 5)             begin n_fail++; $display("FAIL b2b2_ack_cyc: got %0d want 5", e_cyc); end
    n_cmp++; if (rd !== 32'h0000_5A5A)    begin n_fail++; $display("FAIL b2b2_data: got %h want 00005a5a", rd); end
    n_cmp++; if (af !== 18'd14)           begin n_fail++; $display("FAIL b2b2_adr: got %h want e", af); end
  endtask

  task automatic test_cs_drop;
    run_txn(1'b0, 4'hF, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (e_cyc !== 7)             begin n_fail++; $display("FAIL csdrop_ack_cyc: got %0d want 7", e_cyc); end
    n_cmp++; if (rd !== 32'hABCD_1234)    begin n_fail++; $display("FAIL csdrop_data: got %h want abcd1234", rd); end
    n_cmp++; if (we_l !== 0)              begin n_fail++; $display("FAIL csdrop_we_low: got %0d want 0", we_l); end
  endtask

  task automatic test_reset_mid;
    int acks;
    @(negedge clk);
    qs_cs = 1'b1; qs_we = 1'b1; qs_sel = 4'hC; qs_adr = 32'h0000_0020; qs_dat_w = 32'h1234_0000;
    repeat (2) @(negedge clk);
    n_cmp++; if ({sram_ce_n, sram_we_n} !== 2'b00)
      begin n_fail++; $display("FAIL rmid_pre_strobes: got %b want 00", {sram_ce_n, sram_we_n}); end
    n_cmp++; if (sram_adr !== 18'h11)     begin n_fail++; $display("FAIL rmid_pre_adr: got %h want 11", sram_adr); end
    rst = 1'b1; qs_cs = 1'b0;
    #1;
    n_cmp++; if ({sram_ce_n, sram_we_n, sram_dat_oe, qs_ack} !== 4'b1100)
      begin n_fail++; $display("FAIL rmid_async: got %b want 1100", {sram_ce_n, sram_we_n, sram_dat_oe, qs_ack}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (8) begin @(negedge clk); if (qs_ack || qs_err) acks++; end
    n_cmp++; if (acks !== 0)              begin n_fail++; $display("FAIL rmid_no_ack: got %0d want 0", acks); end
    $display("txn reset during HI write, completions after reset=%0d", acks);
    run_txn(1'b0, 4'hF, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (e_cyc !== 7)             begin n_fail++; $display("FAIL rmid_read_cyc: got %0d want 7", e_cyc); end
    n_cmp++; if (rd !== 32'hABCD_1234)    begin n_fail++; $display("FAIL rmid_read_data: got %h want abcd1234", rd); end
  endtask

  initial begin
    test_reset;
    preload(6'd4,  16'h1234);
    preload(6'd5,  16'hABCD);
    preload(6'd9,  16'h7777);
    preload(6'd12, 16'h0F0F);
    preload(6'd13, 16'hF0F0);
    preload(6'd14, 16'h5A5A);
    preload(6'd15, 16'hA5A5);
    test_read32;
    test_write_lo;
    test_write_hi;
    test_read_hi_only;
    test_error;
    test_sel_zero;
    test_back_to_back;
    test_cs_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
